// File: rtl/irq_ctrl_v1.sv
// Interrupt controller: fixed-priority selection of pending, enabled sources,
// with a single outstanding request, CPU acknowledge and software end-of-interrupt.
// Pending, enable, control and status registers sit on a small SFR map.
// Build option: define IRQ_CTRL_EDGE_DET_EN to make sources rising-edge triggered.
// When it is not defined, sources are level sensitive.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | nothing outstanding, arbitrating pending & enabled sources
// REQ     | irq_req high, waiting for irq_ack; irq_id frozen
// SERVICE | CPU handling irq_id, waiting for STAT write (EOI)
module irq_ctrl_v1 #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'hFFFFF864,
    parameter int                    NUM_SRC    = 16,
    localparam int                   IW         = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic [ADDR_WIDTH-1:0] sys_addr,
    input  logic                  sys_wr_en,
    input  logic [DATA_WIDTH-1:0] sys_sw_value,
    input  logic [NUM_SRC-1:0]    irq_src,
    input  logic                  irq_ack,
    output logic [DATA_WIDTH-1:0] sfr_rd_dout,
    output logic                  irq_req,
    output logic [IW-1:0]         irq_id
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_CTRL = BASE_ADDR;
    localparam logic [ADDR_WIDTH-1:0] ADDR_IE   = BASE_ADDR + ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] ADDR_IF   = BASE_ADDR + ADDR_WIDTH'(8);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STAT = BASE_ADDR + ADDR_WIDTH'(12);

    state_t               state_q, state_d;
    logic                 gie_q, gie_d;
    logic [NUM_SRC-1:0]   ie_q, ie_d;
    logic [NUM_SRC-1:0]   if_q, if_d;
    logic [IW-1:0]        id_q, id_d;

    logic                 sel_ctrl, sel_ie, sel_if, sel_stat;
    logic [NUM_SRC-1:0]   evt;
    logic [NUM_SRC-1:0]   pend;
    logic [NUM_SRC-1:0]   w1c_mask;
    logic [NUM_SRC-1:0]   ack_mask;
    logic [IW-1:0]        win_id;
    logic                 eoi;
    logic                 unused_wdata;

    assign sel_ctrl = (sys_addr == ADDR_CTRL);
    assign sel_ie   = (sys_addr == ADDR_IE);
    assign sel_if   = (sys_addr == ADDR_IF);
    assign sel_stat = (sys_addr == ADDR_STAT);

    assign eoi      = sys_wr_en && sel_stat;
    assign pend     = if_q & ie_q;
    assign w1c_mask = (sys_wr_en && sel_if) ? sys_sw_value[NUM_SRC-1:0] : '0;
    assign ack_mask = (state_q == REQ && irq_ack) ? (NUM_SRC'(1) << id_q) : '0;

    // Only the low bits of write data carry register content.
    assign unused_wdata = ^sys_sw_value;

`ifdef IRQ_CTRL_EDGE_DET_EN
    logic [NUM_SRC-1:0] src_prev_q;

    // Previous source sample for rising-edge detection.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) src_prev_q <= '0;
        else            src_prev_q <= irq_src;
    end

    assign evt = irq_src & ~src_prev_q;
`else
    assign evt = irq_src;
`endif

    // Lowest pending & enabled index wins; scan high to low so bit 0 ends up on top.
    always_comb begin
        win_id = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (pend[i]) win_id = IW'(i);
        end
    end

    // Register-file next values; a new event overrides any clear in the same cycle.
    always_comb begin
        gie_d = gie_q;
        ie_d  = ie_q;
        if (sys_wr_en && sel_ctrl) gie_d = sys_sw_value[0];
        if (sys_wr_en && sel_ie)   ie_d  = sys_sw_value[NUM_SRC-1:0];
        if_d  = (if_q & ~w1c_mask & ~ack_mask) | evt;
    end

    // Request FSM next state; irq_id captured only when leaving IDLE.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        case (state_q)
            IDLE: begin
                if (gie_q && |pend) begin
                    state_d = REQ;
                    id_d    = win_id;
                end
            end
            REQ: begin
                if (!gie_q || !pend[id_q]) state_d = IDLE;
                else if (irq_ack)          state_d = SERVICE;
            end
            SERVICE: begin
                if (eoi) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // All state registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
            gie_q   <= 1'b0;
            ie_q    <= '0;
            if_q    <= '0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            gie_q   <= gie_d;
            ie_q    <= ie_d;
            if_q    <= if_d;
            id_q    <= id_d;
        end
    end

    assign irq_req = (state_q == REQ);
    assign irq_id  = id_q;

    // Combinational read mux; zero when no register matches so it can be OR-merged.
    always_comb begin
        sfr_rd_dout = '0;
        if (sel_ctrl) begin
            sfr_rd_dout[0] = gie_q;
        end else if (sel_ie) begin
            sfr_rd_dout[NUM_SRC-1:0] = ie_q;
        end else if (sel_if) begin
            sfr_rd_dout[NUM_SRC-1:0] = if_q;
        end else if (sel_stat) begin
            sfr_rd_dout[DATA_WIDTH-1] = (state_q == SERVICE);
            sfr_rd_dout[DATA_WIDTH-2] = (state_q == REQ);
            sfr_rd_dout[IW-1:0]       = id_q;
        end
    end

endmodule

// File: doc/irq_ctrl_v1.md
IRQ_CTRL_V1 -- requirements
Module: irq_ctrl_v1

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SFR data bus width.
REQ-002 Parameter ADDR_WIDTH, default 32, system address width.
REQ-003 Parameter BASE_ADDR, default 32'hFFFFF864, first SFR address.
REQ-004 Parameter NUM_SRC, default 16, interrupt source count, range 1..DATA_WIDTH; IW = max(1,$clog2(NUM_SRC)).
REQ-005 Port sys_clk  in  1  single clock for all state.
REQ-006 Port sys_rst_n  in  1  reset, asynchronous, active-low.
REQ-007 Port sys_addr  in  ADDR_WIDTH  SFR address.
REQ-008 Port sys_wr_en  in  1  SFR write strobe, already qualified by the SFR region decode.
REQ-009 Port sys_sw_value  in  DATA_WIDTH  SFR write data.
REQ-010 Port irq_src  in  NUM_SRC  peripheral event flags, bit i = source i.
REQ-011 Port irq_ack  in  1  CPU accept pulse for the current request.
REQ-012 Port sfr_rd_dout  out  DATA_WIDTH  SFR read data; all zeros when sys_addr matches no register in this block, so it can be OR-combined onto the SFR read bus.
REQ-013 Port irq_req  out  1  interrupt request to CPU.
REQ-014 Port irq_id  out  IW  index of the requested or in-service source.

Function
REQ-015 SFR map: BASE+0x0 CTRL (bit0 GIE, RW); BASE+0x4 IE (bits NUM_SRC-1:0, RW); BASE+0x8 IF (pending, read, write-1-to-clear); BASE+0xC STAT (read {in_service at bit31, irq_req at bit30, irq_id at LSBs}; any write = EOI).
REQ-016 Reads are combinational from sys_addr; unimplemented bits read 0.
REQ-017 Writes take effect on the sys_clk rising edge with sys_wr_en high and an address match; non-matching writes are ignored.
REQ-018 IF[i] sets on a detected event on irq_src[i], independent of IE and GIE; set wins over a simultaneous W1C or ack-clear in the same cycle.
REQ-019 Selection: lowest-index i with IF[i]&IE[i] wins (fixed priority, bit 0 highest).
REQ-020 FSM states IDLE, REQ, SERVICE; irq_req = (state==REQ).
REQ-021 IDLE->REQ when GIE=1 and |(IF&IE); irq_id is registered on the same edge.
REQ-022 In REQ, irq_id is held stable; a higher-priority arrival does not change it.
REQ-023 REQ->IDLE (withdraw) when IF[irq_id]&IE[irq_id] becomes 0 or GIE becomes 0 before ack; re-arbitration occurs from IDLE on the next cycle.
REQ-024 REQ->SERVICE on irq_ack=1; the same edge clears IF[irq_id].
REQ-025 irq_ack outside REQ is ignored.
REQ-026 SERVICE: irq_req low, no nesting; irq_id is held.
REQ-027 SERVICE->IDLE on a STAT write (EOI); an EOI write in IDLE or REQ is ignored.
REQ-028 Latency: a source event at edge n gives IF set at edge n+1 and irq_req high after edge n+2 (GIE, IE set, state IDLE).

Reset
REQ-029 sys_rst_n low asynchronously forces: state IDLE, CTRL=0, IE=0, IF=0, irq_id=0, irq_req=0, edge-detect history=0.
REQ-030 sfr_rd_dout during reset reflects zeroed registers; a reset mid-REQ or mid-SERVICE discards the request, requiring no EOI.

Configuration
REQ-031 Macro IRQ_CTRL_EDGE_DET_EN defined: IF[i] sets only on a 0->1 transition of irq_src[i], using a registered previous sample.
REQ-032 Macro IRQ_CTRL_EDGE_DET_EN undefined: level-sensitive; IF[i] sets every cycle irq_src[i]=1, so a W1C of a still-high source re-pends on the next edge; no history registers are built.

Verification
REQ-033 GIE=1, IE=0x0004, pulse irq_src[2] 1 cycle -> IF=0x0004, irq_req=1 two cycles later, irq_id=2, STAT=0x40000002.
REQ-034 IE=0x0003, irq_src[1] and irq_src[0] set together -> irq_id=0; ack -> IF=0x0002, STAT bit31=1; EOI -> next cycle REQ with irq_id=1.
REQ-035 In REQ with irq_id=5, W1C 0x20 to IF before ack -> irq_req drops on the next edge, state IDLE, IF=0.
REQ-036 In SERVICE, pulse irq_src[3] (IE[3]=1) -> IF[3]=1, irq_req stays 0 until EOI, then asserts with irq_id=3.
REQ-037 Assert sys_rst_n=0 mid-SERVICE -> irq_req=0, STAT=0, IF=0, CTRL=0 immediately, without a clock edge.
REQ-038 Read of BASE+0x10 or any non-matching address -> sfr_rd_dout=0; with EDGE_DET_EN, irq_src[7] held high 10 cycles and one W1C -> IF[7] stays 0 after the clear.
